random_level_player: RTL and testbench
======================================

# random_level_player

Parametrised successor to the single-ROM random-level DAC driver. Plays one of 2^SEG_BITS equal-length segments of an external synchronous waveform ROM, stepping through the selected segment with a programmable phase step. At each segment boundary it picks the next segment: fixed, sequential, or pseudo-random from an internal LFSR, after a programmable dwell. It drives two DAC data channels, with optional inversion on channel 2, and sits between the PLL-clocked ROM and the DAC pins.

## Interface
- DATA_W, 14: ROM and DAC sample width.
- ADDR_W, 10: ROM address width.
- SEG_BITS, 2: segment-select bits. The block has 2^SEG_BITS segments of 2^(ADDR_W-SEG_BITS) words each (OFF_W = ADDR_W-SEG_BITS).
- DWELL_W, 8: dwell counter width.
- LFSR_W, 16: LFSR width; must be ≥ SEG_BITS.
- SEED, 16'hACE1: LFSR reset value. It must be nonzero.

Ports:
- clk  in  1  sample clock (the 125 MHz DAC clock domain); the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  play enable.
- mode  in  2  segment-selection mode: 0 fixed, 1 sequential, 2 random, 3 reserved (treated as random).
- seg_sel  in  SEG_BITS  segment used in fixed mode.
- step  in  OFF_W  offset increment per cycle.
- dwell  in  DWELL_W  number of extra full segment passes before a reselect. 0 means reselect at every wrap.
- seed_load  in  1  one-cycle pulse that loads seed into the LFSR.
- seed  in  LFSR_W  LFSR load value. A value of 0 loads 1.
- ch2_inv  in  1  when 1, channel 2 outputs the bitwise inverse of the sample.
- rom_addr  out  ADDR_W  ROM address, equal to {seg_cur, offset}, registered.
- rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr.
- da1_data  out  DATA_W  channel 1 sample.
- da2_data  out  DATA_W  channel 2 sample.
- da_valid  out  1  high when da1_data/da2_data carry a sample fetched while en was high.
- seg_cur  out  SEG_BITS  segment currently being addressed.
- seg_switch  out  1  one-cycle pulse in the cycle rom_addr enters a new pass after a reselect.

## Operation
- State IDLE (en=0): offset, seg_cur, pass counter and LFSR hold. rom_addr holds. da1_data and da2_data hold their last values.
- State PLAY (en=1), each cycle:
  - Compute {carry, next_off} = offset + step, evaluated at OFF_W+1 bits.
  - If carry=0: offset ← next_off.
  - If carry=1 (wrap), the residue is discarded:
    - If pass_cnt < dwell: pass_cnt ← pass_cnt+1 and offset ← 0. seg_cur is unchanged.
    - Otherwise (reselect): pass_cnt ← 0, offset ← 0, seg_cur ← next_seg, and seg_switch pulses.
- next_seg by mode:
  - fixed: seg_sel as sampled in the wrap cycle.
  - sequential: seg_cur+1, wrapping modulo 2^SEG_BITS.
  - random: lfsr[SEG_BITS-1:0] from the current LFSR state.
  - The new value may equal seg_cur; seg_switch still pulses.
- step=0: offset is frozen, no wrap occurs and no reselect happens. The same sample repeats.
- LFSR: Fibonacci, maximal-length taps for LFSR_W (16-bit: x^16+x^14+x^13+x^11+1). It shifts every cycle en=1. The LFSR is never zero.
- seed_load has priority over shifting. Loaded value = (seed==0) ? 1 : seed. It takes effect the next cycle and is allowed while en is high or low.
- mode, seg_sel and dwell are sampled only at the wrap cycle; changes mid-pass do not disturb the current pass. step is sampled every cycle.
- Channel data: da1_data ← rom_data. da2_data ← ch2_inv ? ~rom_data : rom_data.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). The first fetch after rst_n deasserts is address 0.

## Timing
- Reset values: rom_addr=0, seg_cur=0, offset=0, pass_cnt=0, lfsr=SEED, da1_data=0, da2_data=0, da_valid=0, seg_switch=0.
- Pipeline: rom_addr registered at edge n → rom_data valid after edge n+1 → da1_data/da2_data registered at edge n+2. Address-to-DAC latency is 2 cycles.
- da_valid is en delayed by 2 registers. It rises 2 cycles after en rises and falls 2 cycles after en falls.
- Segment reselect is gapless: the wrap cycle's rom_addr update already carries the new segment with offset 0. No idle cycle is inserted.
- seg_switch is registered alongside rom_addr and is high for exactly one cycle, the cycle rom_addr = {new_seg, 0}.
- Simultaneous seed_load and wrap in random mode: next_seg uses the pre-load LFSR value.

## Test plan
1. Reset, then en=1, mode=0, seg_sel=2, step=1, dwell=0, ADDR_W=10 → rom_addr runs 512…767 then 512 again. seg_switch pulses every 256 cycles. da1_data equals the ROM word at rom_addr 2 cycles earlier.
2. mode=1, step=4, dwell=1 → each segment is played for 2 passes of 64 cycles. seg_cur goes 0,1,2,3,0. seg_switch pulses every 128 cycles. Offsets 252→0 on wrap, with no residue.
3. mode=2, seed_load with seed=0 → LFSR holds 1. The segment sequence matches a bench LFSR model cycle-exact. Repeating with seed=16'hACE1 reproduces an identical sequence.
4. ch2_inv=1, ROM word 14'h0005 → da2_data=14'h3FFA while da1_data=14'h0005.
5. en dropped mid-pass at offset 100 for 10 cycles → rom_addr holds. da_valid falls 2 cycles after en falls. Playback resumes at offset 100+step.
6. rst_n pulsed low asynchronously mid-pass (not aligned to clk) → all outputs are 0 immediately. After release: rom_addr=0, lfsr=SEED, da_valid=0 for 2 cycles after en.

Source files
------------

// File: rtl/random_level_player.sv
// random_level_player
//   Plays one of 2^SEG_BITS equal-length segments of an external synchronous
//   waveform ROM.
//   - The offset inside the segment advances by 'step' on every enabled cycle.
//   - When the offset wraps past the end of the segment it may pick a new
//     segment. The choice is fixed, sequential, or taken from an internal
//     LFSR, and it is made after 'dwell' extra passes.
//   - The ROM word drives two DAC channels. Channel 2 can be inverted.
//
// Ports
//   clk, rst_n         sample clock, asynchronous active-low reset
//   en                 play enable (low = hold everything)
//   mode               0 fixed, 1 sequential, 2/3 random
//   seg_sel            segment used in fixed mode
//   step               offset increment per enabled cycle
//   dwell              extra full passes before a reselect
//   seed_load, seed    LFSR load strobe / value (0 loads 1)
//   ch2_inv            invert channel 2
//   rom_addr, rom_data ROM address out / data in (1-cycle ROM latency)
//   da1_data, da2_data DAC samples, da_valid marks samples fetched with en=1
//   seg_cur            segment currently addressed
//   seg_switch         one-cycle pulse when rom_addr enters a reselected segment
module random_level_player #(
   parameter int DATA_W   = 14,
   parameter int ADDR_W   = 10,
   parameter int SEG_BITS = 2,
   parameter int DWELL_W  = 8,
   parameter int LFSR_W   = 16,
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic [SEG_BITS-1:0]          seg_sel,
   input  logic [ADDR_W-SEG_BITS-1:0]   step,
   input  logic [DWELL_W-1:0]           dwell,
   input  logic                         seed_load,
   input  logic [LFSR_W-1:0]            seed,
   input  logic                         ch2_inv,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [DATA_W-1:0]            rom_data,
   output logic [DATA_W-1:0]            da1_data,
   output logic [DATA_W-1:0]            da2_data,
   output logic                         da_valid,
   output logic [SEG_BITS-1:0]          seg_cur,
   output logic                         seg_switch
);

   localparam int OFF_W = ADDR_W - SEG_BITS;

   // Fibonacci tap masks (bit t-1 set for tap x^t) of maximal-length
   // polynomials. Widths without a table entry fall back to x^w + x^(w-1),
   // which is not maximal for every w.
   function automatic logic [LFSR_W-1:0] tap_mask(input int w);
      logic [63:0] m;
      case (w)
         2:  m = 64'h3;
         3:  m = 64'h6;
         4:  m = 64'hC;
         5:  m = 64'h14;
         6:  m = 64'h30;
         7:  m = 64'h60;
         8:  m = 64'hB8;
         9:  m = 64'h110;
         10: m = 64'h240;
         11: m = 64'h500;
         12: m = 64'h829;
         13: m = 64'h100D;
         14: m = 64'h2015;
         15: m = 64'h6000;
         16: m = 64'hB400;
         17: m = 64'h12000;
         18: m = 64'h20400;
         19: m = 64'h40023;
         20: m = 64'h90000;
         24: m = 64'hE10000;
         32: m = 64'h80200003;
         default: m = (64'd1 << (w - 1)) | (64'd1 << (w - 2));
      endcase
      return m[LFSR_W-1:0];
   endfunction

   localparam logic [LFSR_W-1:0] TAPS = tap_mask(LFSR_W);

   typedef enum logic {IDLE, PLAY} state_t;
   state_t state;

   logic [OFF_W-1:0]    off_q, off_d;
   logic [SEG_BITS-1:0] seg_q, seg_d, next_seg;
   logic [DWELL_W-1:0]  pass_q, pass_d;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic                sw_q, sw_d;
   logic [1:0]          vld_pipe_q, vld_pipe_d;
   logic [DATA_W-1:0]   da1_q, da1_d, da2_q, da2_d;
   logic [OFF_W:0]      sum;
   logic                fb;

   // The play state is simply 'en'. Nothing is latched across cycles, so
   // there is no state register, only this decode.
   assign state = en ? PLAY : IDLE;

   always_comb begin
      sum = {1'b0, off_q} + {1'b0, step};
      fb  = ^(lfsr_q & TAPS);

      case (mode)
         2'd0:    next_seg = seg_sel;
         2'd1:    next_seg = seg_q + SEG_BITS'(1);
         default: next_seg = lfsr_q[SEG_BITS-1:0];   // pre-shift, pre-load value
      endcase

      off_d  = off_q;
      seg_d  = seg_q;
      pass_d = pass_q;
      lfsr_d = lfsr_q;
      sw_d   = 1'b0;

      if (state == PLAY) begin
         lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
         if (!sum[OFF_W]) begin
            off_d = sum[OFF_W-1:0];
         end else begin
            // A wrap discards the residue, so every pass starts at offset 0.
            off_d = '0;
            if (pass_q < dwell) begin
               pass_d = pass_q + DWELL_W'(1);
            end else begin
               pass_d = '0;
               seg_d  = next_seg;
               sw_d   = 1'b1;
            end
         end
      end

      // A load wins over the shift. A zero load would lock the LFSR up.
      if (seed_load)
         lfsr_d = (seed == '0) ? LFSR_W'(1) : seed;

      // Two stages: one for the ROM read latency and one for the DAC register.
      vld_pipe_d = {vld_pipe_q[0], en};

      da1_d = da1_q;
      da2_d = da2_q;
      if (vld_pipe_q[0]) begin
         da1_d = rom_data;
         da2_d = ch2_inv ? ~rom_data : rom_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_q      <= '0;
         seg_q      <= '0;
         pass_q     <= '0;
         lfsr_q     <= SEED;
         sw_q       <= 1'b0;
         vld_pipe_q <= '0;
         da1_q      <= '0;
         da2_q      <= '0;
      end else begin
         off_q      <= off_d;
         seg_q      <= seg_d;
         pass_q     <= pass_d;
         lfsr_q     <= lfsr_d;
         sw_q       <= sw_d;
         vld_pipe_q <= vld_pipe_d;
         da1_q      <= da1_d;
         da2_q      <= da2_d;
      end
   end

   assign rom_addr   = {seg_q, off_q};
   assign seg_cur    = seg_q;
   assign seg_switch = sw_q;
   assign da_valid   = vld_pipe_q[1];
   assign da1_data   = da1_q;
   assign da2_data   = da2_q;

endmodule

// File: tb/tb_random_level_player.sv
module tb_random_level_player;

   logic        clk = 1'b0;
   logic        rst_n, en, seed_load, ch2_inv;
   logic [1:0]  mode, seg_sel, seg_cur;
   logic [7:0]  step, dwell;
   logic [15:0] seed;
   logic [9:0]  rom_addr;
   logic [13:0] rom_data, da1_data, da2_data;
   logic        da_valid, seg_switch;

   random_level_player dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .seg_sel(seg_sel),
      .step(step), .dwell(dwell), .seed_load(seed_load), .seed(seed),
      .ch2_inv(ch2_inv), .rom_addr(rom_addr), .rom_data(rom_data),
      .da1_data(da1_data), .da2_data(da2_data), .da_valid(da_valid),
      .seg_cur(seg_cur), .seg_switch(seg_switch)
   );

   always #5 clk = ~clk;

   function automatic logic [13:0] rom_word(input logic [9:0] a);
      logic [31:0] t;
      t = 32'(a) * 37 + 5;
      return t[13:0];
   endfunction

   // Synchronous ROM with one cycle of latency.
   always @(posedge clk) rom_data <= rom_word(rom_addr);

   function automatic logic [15:0] lfsr_next(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   typedef struct packed {
      logic [13:0] d1;
      logic [13:0] d2;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [9:0]  exp_addr;
   logic [15:0] m_lfsr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: each valid DAC sample is compared with the oldest expected entry.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && da_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=valid_sample required=no_sample da1=%0h", da1_data);
         end else begin
            e = sb_q.pop_front();
            chk("da1", 32'(da1_data), 32'(e.d1));
            chk("da2", 32'(da2_data), 32'(e.d2));
         end
      end
   end

   // One clock. If en is high, the word at the current address is fetched,
   // so its sample goes to the scoreboard. After the edge, the address,
   // segment and switch pulse are checked.
   task automatic cyc(input logic [9:0] nxt_addr, input logic nxt_sw, input string name);
      exp_t e;
      if (en) begin
         e.d1 = rom_word(exp_addr);
         e.d2 = ch2_inv ? ~e.d1 : e.d1;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk(name, {19'd0, rom_addr, seg_cur, seg_switch}, {19'd0, nxt_addr, nxt_addr[9:8], nxt_sw});
      exp_addr = nxt_addr;
   endtask

   // Random mode with dwell=0. The LFSR model supplies the segment chosen at each wrap.
   task automatic rand_run(input int n, input logic [15:0] start);
      logic [8:0] s;
      logic [1:0] sg;
      logic [7:0] of;
      logic       sw;
      m_lfsr = start;
      en = 1'b1;
      for (int i = 0; i < n; i++) begin
         sg = exp_addr[9:8];
         s  = {1'b0, exp_addr[7:0]} + {1'b0, step};
         sw = 1'b0;
         of = s[7:0];
         if (s[8]) begin
            sg = m_lfsr[1:0];
            of = 8'd0;
            sw = 1'b1;
         end
         m_lfsr = lfsr_next(m_lfsr);
         cyc({sg, of}, sw, "rand_addr");
      end
   endtask

   task automatic do_reset();
      en = 1'b0;
      seed_load = 1'b0;
      rst_n = 1'b0;
      sb_q.delete();
      exp_addr = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; ch2_inv = 1'b0;
      mode = 2'd0; seg_sel = 2'd0; step = 8'd0; dwell = 8'd0; seed = 16'd0;
      exp_addr = '0;

      // Reset state, then fixed segment 2 with step 1.
      do_reset();
      chk("reset_state", {rom_addr, seg_cur, da1_data, da2_data, da_valid, seg_switch}, 32'd0);
      mode = 2'd0; seg_sel = 2'd2; step = 8'd1; dwell = 8'd0; en = 1'b1;
      for (int e = 1; e <= 514; e++) begin
         if (e < 256) cyc(10'(e), 1'b0, "fixed_addr");
         else         cyc(10'(512 + (e - 256) % 256), ((e - 256) % 256) == 0, "fixed_addr");
      end

      // Sequential mode, step 4, two passes per segment.
      do_reset();
      mode = 2'd1; step = 8'd4; dwell = 8'd1; en = 1'b1;
      for (int e = 1; e <= 513; e++)
         cyc(10'(((e / 128) % 4) * 256 + (e % 64) * 4), (e % 128) == 0, "seq_addr");

      // Channel 2 inversion: address 0 holds word 5.
      do_reset();
      ch2_inv = 1'b1; mode = 2'd0; seg_sel = 2'd0; step = 8'd1; dwell = 8'd0; en = 1'b1;
      cyc(10'd1, 1'b0, "inv_addr");
      cyc(10'd2, 1'b0, "inv_addr");
      chk("inv_dv", 32'(da_valid), 32'd1);
      chk("inv_da1", 32'(da1_data), 32'h0005);
      chk("inv_da2", 32'(da2_data), 32'h3FFA);

      // en dropped at offset 100 for 10 cycles.
      do_reset();
      ch2_inv = 1'b0; mode = 2'd0; seg_sel = 2'd1; step = 8'd4; dwell = 8'd0; en = 1'b1;
      for (int e = 1; e <= 25; e++) cyc(10'(e * 4), 1'b0, "pause_run");
      en = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         cyc(10'd100, 1'b0, "pause_hold");
         if (i == 1) chk("pause_dv1", 32'(da_valid), 32'd1);
         if (i == 2) chk("pause_dv2", 32'(da_valid), 32'd0);
      end
      chk("pause_da1_hold", 32'(da1_data), 32'(rom_word(10'd96)));
      en = 1'b1;
      cyc(10'd104, 1'b0, "pause_resume");
      cyc(10'd108, 1'b0, "pause_resume");

      // Asynchronous reset mid-pass, off the clock edge.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst", {rom_addr, seg_cur, da1_data, da2_data, da_valid, seg_switch}, 32'd0);
      sb_q.delete();
      exp_addr = '0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("rst_rel_addr", 32'(rom_addr), 32'd0);
      mode = 2'd2; step = 8'd128; dwell = 8'd0;
      // LFSR must come out of reset at SEED.
      rand_run(1, 16'hACE1);
      chk("rst_dv_e1", 32'(da_valid), 32'd0);
      rand_run(1, m_lfsr);
      chk("rst_dv_e2", 32'(da_valid), 32'd1);
      rand_run(38, m_lfsr);

      // Reload ACE1: the sequence restarts from the same state.
      en = 1'b0; seed = 16'hACE1; seed_load = 1'b1;
      cyc(exp_addr, 1'b0, "load_hold");
      seed_load = 1'b0;
      rand_run(40, 16'hACE1);

      // Seed 0 loads 1.
      en = 1'b0; seed = 16'h0000; seed_load = 1'b1;
      cyc(exp_addr, 1'b0, "load_hold");
      seed_load = 1'b0;
      rand_run(40, 16'h0001);

      // A seed load in a wrap cycle: this reselect uses the old LFSR value.
      rand_run(1, m_lfsr);
      seed = 16'h1234; seed_load = 1'b1;
      rand_run(1, m_lfsr);
      seed_load = 1'b0;
      rand_run(10, 16'h1234);

      // Drain: every expected sample must have been presented.
      en = 1'b0;
      repeat (3) cyc(exp_addr, 1'b0, "drain_hold");
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
